copy_array_host_ctrl: RTL and testbench
=======================================

Name: copy_array_host_ctrl

Overview:
Hardware host/responder for the array-copy core (`copy_array_to_array`-style initiator with `Start`/`Ack`, read index `I`, write index `J` and write strobe).
- Owns the source array M and destination array N, each 10 x 4 bits.
- Serves the core's M read port combinationally and captures its N writes.
- Loads M from a streaming input, sequences the core's `Start`/`Done`/`Ack` handshake, then streams N out. It replaces the simulation-only testbench environment in synthesizable designs.

Parameters:
- DEPTH, 10, number of entries in M and N (index width fixed at 4 bits, DEPTH <= 16).
- DW, 4, element width in bits.
- TIMEOUT, 255, max clocks to wait for `Core_Done` before aborting the run.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- In_Valid  in  1  load stream: `In_Data` valid.
- In_Data  in  DW  load stream element; loaded into M[0], M[1], ... in arrival order.
- In_Ready  out  1  load stream accept.
- Out_Valid  out  1  dump stream: `Out_Data` valid.
- Out_Data  out  DW  dump stream element N[k].
- Out_Ready  in  1  dump stream accept.
- Core_Start  out  1  start pulse to core.
- Core_Ack  out  1  acknowledge pulse to core.
- Core_Done  in  1  core is in its DONE state.
- I  in  4  core read index.
- Ms_of_I  out  DW  M[I]; combinational; 0 when I >= DEPTH.
- J  in  4  core write index.
- Ns_of_J_Write  in  1  core write strobe.
- Ns_of_J_Data  in  DW  data written to N[J].
- Busy  out  1  high in every state except IDLE.
- Timeout_Err  out  1  sticky; set on run timeout, cleared by next load.

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE, load/dump counter k=0.
  - All outputs 0 except `Ms_of_I`, which stays combinational.
  - M and N contents are not reset.
- IDLE: `In_Ready`=1. On the first `In_Valid`&`In_Ready`: write M[0], set k=1, clear `Timeout_Err`, go to LOAD.
- LOAD:
  - `In_Ready`=1; each handshake writes M[k] and increments k.
  - After writing M[DEPTH-1]: k=0, go to START. No extra beat is accepted.
- START: `Core_Start`=1 for exactly one clock; the wait counter clears; go to RUN.
- RUN:
  - N writes: when `Ns_of_J_Write`=1 and J < DEPTH, N[J] <= `Ns_of_J_Data` on the clock edge. Writes with J >= DEPTH are ignored. Writes are honored in every state, so a late write in ACK is still captured.
  - `Core_Done`=1: go to ACK. Done is already high in the cycle after Start: legal, go to ACK.
  - Wait counter reaches TIMEOUT with `Core_Done` still 0: set `Timeout_Err`, go to ACK (Ack is still issued to recover the core).
- ACK: `Core_Ack`=1 for one clock; go to DUMP with k=0.
- DUMP:
  - `Out_Valid`=1, `Out_Data`=N[k].
  - Data holds stable while `Out_Ready`=0.
  - On handshake k++. After handshaking k=DEPTH-1, go to IDLE with k=0.
- Latency: with `In_Valid` and `Out_Ready` held at 1 and a core taking C clocks, load takes DEPTH clocks, then Start 1, Run C, Ack 1, dump DEPTH.
- `Core_Start` and `Core_Ack` are never high in the same cycle; each is exactly one clock wide.
- `Busy`=1 in LOAD, START, RUN, ACK, DUMP.
- Reset asserted mid-operation: immediate return to IDLE; the partial load or dump is discarded; the core must be reset together with this block.
- Counter widths: k is 4 bits; the wait counter is 8 bits and saturates.

Optional Feature:
- Macro `COPY_HOST_CYCLE_COUNT_EN`.
- Defined:
  - Adds output `Clocks_Taken` [7:0]: the number of clocks from the `Core_Start` cycle (exclusive) to the first cycle `Core_Done` is seen (inclusive).
  - Latched on entry to ACK and held until the next START; reset value 0.
  - On timeout it reads TIMEOUT.
- Undefined: the port and its counter logic are absent; all other behaviour is identical.

Test Plan:
- Load M = 2,5,7,9,A,B,C,D,E,F with a core model that copies M[I]→N[J] for I=0..9 and raises Done after 12 clocks → one-cycle `Core_Start`, one-cycle `Core_Ack`, dump emits 2,5,7,9,A,B,C,D,E,F in order, `Busy` drops after the 10th dump beat.
- Dump backpressure: `Out_Ready` toggles 0/1 every cycle → each N[k] is held until accepted; exactly 10 beats; no duplicates.
- Core never asserts Done, TIMEOUT=255 → `Timeout_Err`=1 after 255 clocks in RUN, `Core_Ack` pulses once, dump proceeds; the next load clears `Timeout_Err`.
- Core writes with J=10 and J=15 → N unchanged; `Ms_of_I`=0 for I=12.
- Reset_n pulled low in the middle of DUMP (k=4) → outputs 0 immediately, state IDLE, `In_Ready`=1 after release.
- With `COPY_HOST_CYCLE_COUNT_EN` defined and Done asserted 12 clocks after Start → `Clocks_Taken`=12 from the ACK cycle onward until the next START.

Source files
------------

// File: rtl/copy_array_host_ctrl_if.sv
// Bus bundle between copy_array_host_ctrl (slave side) and its environment/core (master side).
// Clocks_Taken exists only when COPY_HOST_CYCLE_COUNT_EN is defined.
interface copy_array_host_ctrl_if #(
  parameter int DW = 4
);
  logic          In_Valid;
  logic [DW-1:0] In_Data;
  logic          In_Ready;
  logic          Out_Valid;
  logic [DW-1:0] Out_Data;
  logic          Out_Ready;
  logic          Core_Start;
  logic          Core_Ack;
  logic          Core_Done;
  logic [3:0]    I;
  logic [DW-1:0] Ms_of_I;
  logic [3:0]    J;
  logic          Ns_of_J_Write;
  logic [DW-1:0] Ns_of_J_Data;
  logic          Busy;
  logic          Timeout_Err;
`ifdef COPY_HOST_CYCLE_COUNT_EN
  logic [7:0]    Clocks_Taken;
`endif

  modport master (
    output In_Valid, In_Data, Out_Ready, Core_Done, I, J, Ns_of_J_Write, Ns_of_J_Data,
`ifdef COPY_HOST_CYCLE_COUNT_EN
    input  Clocks_Taken,
`endif
    input  In_Ready, Out_Valid, Out_Data, Core_Start, Core_Ack, Ms_of_I, Busy, Timeout_Err
  );

  modport slave (
    input  In_Valid, In_Data, Out_Ready, Core_Done, I, J, Ns_of_J_Write, Ns_of_J_Data,
`ifdef COPY_HOST_CYCLE_COUNT_EN
    output Clocks_Taken,
`endif
    output In_Ready, Out_Valid, Out_Data, Core_Start, Core_Ack, Ms_of_I, Busy, Timeout_Err
  );
endinterface

// File: rtl/copy_array_host_ctrl.sv
// Host/responder for the array-copy core: loads M, sequences Start/Done/Ack, dumps N.
// Optional Clocks_Taken measurement is enabled by defining COPY_HOST_CYCLE_COUNT_EN.
module copy_array_host_ctrl #(
  parameter int DEPTH   = 10,
  parameter int DW      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  copy_array_host_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_ACK   = 3'd4,
    ST_DUMP  = 3'd5
  } state_t;

  localparam logic [3:0] LAST_IDX  = 4'(DEPTH - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  state_t        state_r, state_s;
  logic [3:0]    k_r, k_s;
  logic [7:0]    wait_r, wait_s;
  logic          timeout_s;
  logic          in_hs_s, out_hs_s;
  logic          in_ready_r, out_valid_r, core_start_r, core_ack_r, busy_r, timeout_err_r;
  logic [DW-1:0] out_data_r, out_data_s, ms_of_i_s;
  logic [DW-1:0] m_mem_r [DEPTH];
  logic [DW-1:0] n_mem_r [DEPTH];

  assign in_hs_s  = bus.In_Valid & in_ready_r;
  assign out_hs_s = out_valid_r & bus.Out_Ready;

  // Next-state, load/dump index and run-wait counter
  always_comb begin
    state_s   = state_r;
    k_s       = k_r;
    wait_s    = wait_r;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_hs_s) begin
          state_s = ST_LOAD;
          k_s     = 4'd1;
        end else begin
          k_s     = 4'd0;
        end
      end
      ST_LOAD: begin
        if (in_hs_s && (k_r == LAST_IDX)) begin
          state_s = ST_START;
          k_s     = 4'd0;
        end else if (in_hs_s) begin
          k_s     = k_r + 4'd1;
        end else begin
          k_s     = k_r;
        end
      end
      ST_START: begin
        wait_s  = 8'd0;
        state_s = ST_RUN;
      end
      ST_RUN: begin
        if (bus.Core_Done) begin
          state_s = ST_ACK;
        end else if (wait_r >= WAIT_LAST) begin
          // Ack is still issued so the core is released from its wait
          timeout_s = 1'b1;
          state_s   = ST_ACK;
        end else begin
          wait_s = sat_inc8(wait_r);
        end
      end
      ST_ACK: begin
        state_s = ST_DUMP;
        k_s     = 4'd0;
      end
      ST_DUMP: begin
        if (out_hs_s && (k_r == LAST_IDX)) begin
          state_s = ST_IDLE;
          k_s     = 4'd0;
        end else if (out_hs_s) begin
          k_s     = k_r + 4'd1;
        end else begin
          k_s     = k_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        k_s     = 4'd0;
      end
    endcase
  end

  // Next dump word: N[k_s], forwarding a same-cycle core write so a late write in ACK shows up
  always_comb begin
    out_data_s = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (k_s == 4'(e)) begin
        out_data_s = n_mem_r[e];
      end else begin
        out_data_s = out_data_s;
      end
    end
    if (bus.Ns_of_J_Write && (bus.J == k_s)) begin
      out_data_s = bus.Ns_of_J_Data;
    end else begin
      out_data_s = out_data_s;
    end
  end

  // Combinational M read port for the core; out-of-range indices read as zero
  always_comb begin
    ms_of_i_s = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (bus.I == 4'(e)) begin
        ms_of_i_s = m_mem_r[e];
      end else begin
        ms_of_i_s = ms_of_i_s;
      end
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r       <= ST_IDLE;
      k_r           <= 4'd0;
      wait_r        <= 8'd0;
      in_ready_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      core_start_r  <= 1'b0;
      core_ack_r    <= 1'b0;
      busy_r        <= 1'b0;
      out_data_r    <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      k_r          <= k_s;
      wait_r       <= wait_s;
      in_ready_r   <= (state_s == ST_IDLE) || (state_s == ST_LOAD);
      out_valid_r  <= (state_s == ST_DUMP);
      core_start_r <= (state_s == ST_START);
      core_ack_r   <= (state_s == ST_ACK);
      busy_r       <= (state_s != ST_IDLE);
      // Dump word only advances on entry to DUMP or after a handshake, so it holds under backpressure
      if ((state_s == ST_DUMP) && ((state_r != ST_DUMP) || out_hs_s)) begin
        out_data_r <= out_data_s;
      end else if (state_s != ST_DUMP) begin
        out_data_r <= '0;
      end else begin
        out_data_r <= out_data_r;
      end
      if (timeout_s) begin
        timeout_err_r <= 1'b1;
      end else if ((state_r == ST_IDLE) && in_hs_s) begin
        timeout_err_r <= 1'b0;
      end else begin
        timeout_err_r <= timeout_err_r;
      end
    end
  end

  // M/N storage: no reset; N writes are honoured in every state
  always_ff @(posedge Clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (in_hs_s && (k_r == 4'(e))) begin
        m_mem_r[e] <= bus.In_Data;
      end
      if (bus.Ns_of_J_Write && (bus.J == 4'(e))) begin
        n_mem_r[e] <= bus.Ns_of_J_Data;
      end
    end
  end

`ifdef COPY_HOST_CYCLE_COUNT_EN
  logic [7:0] clocks_taken_r;

  // Latch the Run length (Start exclusive, Done cycle inclusive) when entering ACK
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clocks_taken_r <= 8'd0;
    end else if ((state_r == ST_RUN) && (state_s == ST_ACK)) begin
      clocks_taken_r <= sat_inc8(wait_r);
    end else begin
      clocks_taken_r <= clocks_taken_r;
    end
  end

  assign bus.Clocks_Taken = clocks_taken_r;
`endif

  assign bus.In_Ready    = in_ready_r;
  assign bus.Out_Valid   = out_valid_r;
  assign bus.Out_Data    = out_data_r;
  assign bus.Core_Start  = core_start_r;
  assign bus.Core_Ack    = core_ack_r;
  assign bus.Busy        = busy_r;
  assign bus.Timeout_Err = timeout_err_r;
  assign bus.Ms_of_I     = ms_of_i_s;

endmodule

// File: tb/tb_copy_array_host_ctrl.sv
// Bench for copy_array_host_ctrl: plays the load/dump streams and the copy core, and
// checks every output each cycle against a transaction-level timeline model.
module tb_copy_array_host_ctrl;
  localparam int DEPTH   = 10;
  localparam int DW      = 4;
  localparam int TIMEOUT = 255;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  copy_array_host_ctrl_if #(.DW(DW)) bus ();

  copy_array_host_ctrl #(.DEPTH(DEPTH), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  // Model: contents of M/N as the bench wrote them, plus expected outputs for the current cycle
  logic [3:0] exp_m [DEPTH];
  bit         m_known [DEPTH];
  logic [3:0] exp_n [DEPTH];
  bit         e_in_ready, e_start, e_ack, e_busy, e_out_valid, e_err;
  logic [3:0] e_out_data;
  logic [7:0] e_clocks;
  bit         chk_en;
  logic [3:0] got_q [$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_exp(input bit ir, input bit st, input bit ak, input bit bz,
                         input bit ov, input logic [3:0] od);
    e_in_ready  = ir;
    e_start     = st;
    e_ack       = ak;
    e_busy      = bz;
    e_out_valid = ov;
    e_out_data  = od;
  endtask

  // Single compare process, mid-cycle
  always @(negedge Clk) begin
    if (chk_en) begin
      check("In_Ready", 8'(bus.In_Ready), 8'(e_in_ready));
      check("Core_Start", 8'(bus.Core_Start), 8'(e_start));
      check("Core_Ack", 8'(bus.Core_Ack), 8'(e_ack));
      check("Busy", 8'(bus.Busy), 8'(e_busy));
      check("Out_Valid", 8'(bus.Out_Valid), 8'(e_out_valid));
      check("Timeout_Err", 8'(bus.Timeout_Err), 8'(e_err));
      if (e_out_valid) check("Out_Data", 8'(bus.Out_Data), 8'(e_out_data));
      if (bus.I >= 4'd10) check("Ms_of_I oor", 8'(bus.Ms_of_I), 8'd0);
      else if (m_known[bus.I]) check("Ms_of_I", 8'(bus.Ms_of_I), 8'(exp_m[bus.I]));
`ifdef COPY_HOST_CYCLE_COUNT_EN
      check("Clocks_Taken", bus.Clocks_Taken, e_clocks);
`endif
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    bus.In_Valid = 1'b0; bus.Out_Ready = 1'b0; bus.Core_Done = 1'b0; bus.Ns_of_J_Write = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    e_err = 1'b0;
    e_clocks = 8'd0;
    #1;
    check("rst Busy now", 8'(bus.Busy), 8'd0);
    check("rst Out_Valid now", 8'(bus.Out_Valid), 8'd0);
    check("rst In_Ready now", 8'(bus.In_Ready), 8'd0);
    tick();
    tick();
    Reset_n = 1'b1;
    tick();
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  // One full host run: load vals, core behaviour, Ack, dump. Entered and left in an IDLE cycle.
  task automatic run_txn(input logic [3:0] vals [DEPTH], input int done_at, input bit copy_en,
                         input bit bp, input bit bad_wr, input int ack_wr_j,
                         input logic [3:0] ack_wr_d, input int rst_at_k, output int beats);
    int  c;
    int  k;
    bit  timed_out;
    bit  did_copy;
    bit  rdy;
    bit  tog;
    beats = 0;
    got_q.delete();
    for (int b = 0; b < DEPTH; b++) begin
      bus.In_Valid = 1'b1;
      bus.In_Data  = vals[b];
      tick();
      exp_m[b]   = vals[b];
      m_known[b] = 1'b1;
      if (b == 0) e_err = 1'b0;
      if (b < DEPTH - 1) set_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
      else               set_exp(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    end
    bus.In_Valid  = 1'b0;
    bus.In_Data   = 4'h0;
    bus.Core_Done = (done_at == 1);
    tick();
    set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    c = 1;
    timed_out = 1'b0;
    forever begin
      bus.Ns_of_J_Write = 1'b0;
      did_copy = 1'b0;
      if (copy_en && (c <= DEPTH)) begin
        bus.I = 4'(c - 1);
        bus.J = 4'(c - 1);
        #1;
        bus.Ns_of_J_Data  = bus.Ms_of_I;
        bus.Ns_of_J_Write = 1'b1;
        did_copy = 1'b1;
      end else if (bad_wr && ((c == DEPTH + 1) || (c == DEPTH + 2))) begin
        bus.I = 4'd12;
        bus.J = (c == DEPTH + 1) ? 4'd10 : 4'd15;
        bus.Ns_of_J_Data  = 4'hF;
        bus.Ns_of_J_Write = 1'b1;
      end
      bus.Core_Done = (done_at > 0) && (c >= done_at);
      tick();
      if (did_copy) exp_n[c - 1] = exp_m[c - 1];
      if ((done_at > 0) && (c == done_at)) break;
      if (c == TIMEOUT) begin
        timed_out = 1'b1;
        break;
      end
      c++;
    end
    bus.Ns_of_J_Write = 1'b0;
    if (timed_out) e_err = 1'b1;
    e_clocks = timed_out ? 8'(TIMEOUT) : 8'(done_at);
    set_exp(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    if (ack_wr_j >= 0) begin
      bus.J = 4'(ack_wr_j);
      bus.Ns_of_J_Data  = ack_wr_d;
      bus.Ns_of_J_Write = 1'b1;
    end
    tick();
    if ((ack_wr_j >= 0) && (ack_wr_j < DEPTH)) exp_n[ack_wr_j] = ack_wr_d;
    bus.Ns_of_J_Write = 1'b0;
    bus.Core_Done = 1'b0;
    k = 0;
    tog = 1'b0;
    while (k < DEPTH) begin
      set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, exp_n[k]);
      if (k == rst_at_k) begin
        do_reset();
        return;
      end
      rdy = bp ? tog : 1'b1;
      tog = ~tog;
      bus.Out_Ready = rdy;
      @(negedge Clk);
      if (rdy) got_q.push_back(bus.Out_Data);
      tick();
      if (rdy) begin
        k++;
        beats++;
      end
    end
    bus.Out_Ready = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic check_dump(input string tag, input logic [3:0] lit [DEPTH], input int beats);
    check({tag, " beats"}, 8'(beats), 8'd10);
    check({tag, " queue size"}, 8'(got_q.size()), 8'd10);
    for (int i = 0; i < DEPTH; i++) begin
      if (i < got_q.size()) check($sformatf("%s beat%0d", tag, i), 8'(got_q[i]), 8'(lit[i]));
    end
  endtask

  initial begin
    logic [3:0] va [DEPTH] = '{4'h2, 4'h5, 4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    logic [3:0] vb [DEPTH] = '{4'h1, 4'h3, 4'h0, 4'h8, 4'h6, 4'h4, 4'hF, 4'hE, 4'h2, 4'h9};
    logic [3:0] vc [DEPTH] = '{4'hF, 4'h0, 4'hA, 4'h5, 4'h3, 4'hC, 4'h1, 4'h7, 4'hB, 4'h4};
    logic [3:0] vd [DEPTH] = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8};
    logic [3:0] ld [DEPTH] = '{4'h6, 4'h0, 4'hA, 4'h5, 4'h3, 4'hC, 4'h1, 4'h7, 4'hB, 4'h4};
    logic [3:0] ve [DEPTH] = '{4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA};
    logic [3:0] vf [DEPTH] = '{4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};
    int beats;

    bus.In_Valid = 1'b0; bus.In_Data = 4'h0; bus.Out_Ready = 1'b0; bus.Core_Done = 1'b0;
    bus.I = 4'd12; bus.J = 4'd0; bus.Ns_of_J_Write = 1'b0; bus.Ns_of_J_Data = 4'h0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    e_err = 1'b0;
    e_clocks = 8'd0;
    chk_en = 1'b1;
    tick();
    tick();
    Reset_n = 1'b1;
    tick();
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Nominal copy, Done 12 clocks after Start
    run_txn(va, 12, 1'b1, 1'b0, 1'b0, -1, 4'h0, -1, beats);
    check_dump("A", va, beats);
`ifdef COPY_HOST_CYCLE_COUNT_EN
    check("A Clocks_Taken literal", bus.Clocks_Taken, 8'd12);
`endif

    // Dump backpressure and out-of-range writes (J=10, J=15, I=12)
    run_txn(vb, 15, 1'b1, 1'b1, 1'b1, -1, 4'h0, -1, beats);
    check_dump("B", vb, beats);

    // Core never finishes: timeout path
    run_txn(vc, 0, 1'b1, 1'b0, 1'b0, -1, 4'h0, -1, beats);
    check_dump("C", vc, beats);
    check("C Timeout_Err literal", 8'(bus.Timeout_Err), 8'd1);
`ifdef COPY_HOST_CYCLE_COUNT_EN
    check("C Clocks_Taken literal", bus.Clocks_Taken, 8'd255);
`endif

    // Done already high after Start, no copy, late write to N[0] during Ack
    run_txn(vd, 1, 1'b0, 1'b0, 1'b0, 0, 4'h6, -1, beats);
    check_dump("D", ld, beats);
    check("D Timeout_Err cleared", 8'(bus.Timeout_Err), 8'd0);

    // Reset in the middle of the dump at k=4
    run_txn(ve, 12, 1'b1, 1'b0, 1'b0, -1, 4'h0, 4, beats);
    check("E beats before reset", 8'(beats), 8'd4);
    check("E In_Ready after reset", 8'(bus.In_Ready), 8'd1);
    check("E Busy after reset", 8'(bus.Busy), 8'd0);

    // Recovery run after reset
    run_txn(vf, 11, 1'b1, 1'b0, 1'b0, -1, 4'h0, -1, beats);
    check_dump("F", vf, beats);

    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
